param_cam: RTL and testbench
============================

Name: param_cam

Overview:
- Parametrised ternary content-addressable memory with per-entry valid bits and per-entry don't-care masks.
- Reports lowest-index match, multi-hit flag and hit count through one registered result stage.
- Adds single-entry invalidate, single-cycle flush and a free-entry tracker for allocation by the lookup/table-management logic in the memory subsystem.

Parameters:
- DW, 16, key/data width in bits.
- DEPTH, 256, number of entries (power of two, >=2).
- AW, $clog2(DEPTH), address width (derived, not overridden).
- CW, $clog2(DEPTH)+1, hit-count width (derived).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  global qualifier; when 0, no write/invalidate/flush/search takes effect.
- wr_en  in  1  write request.
- wr_addr  in  AW  write entry index.
- wr_data  in  DW  stored value.
- wr_mask  in  DW  stored care-mask; 1 = bit compared, 0 = don't care.
- inv_en  in  1  invalidate request.
- inv_addr  in  AW  entry to invalidate.
- flush  in  1  clear all valid bits.
- srch_en  in  1  search request.
- srch_key  in  DW  search key.
- match_valid  out  1  result strobe, one cycle after an accepted search.
- match  out  1  at least one valid entry matched.
- multi_match  out  1  two or more valid entries matched.
- match_addr  out  AW  lowest matching index.
- match_cnt  out  CW  number of matching valid entries.
- full  out  1  all entries valid.
- free_addr  out  AW  lowest invalid index; 0 when full.

Behaviour:
- Reset (async): all valid bits 0. match_valid, match and multi_match = 0; match_addr = 0; match_cnt = 0. Data/mask arrays are not reset.
- Entry i hits when valid[i]=1 and ((data[i] ^ srch_key) & mask[i]) == 0.
- An invalid entry never hits. A mask of all zeros on a valid entry hits every key.
- Search latency is 1 cycle: result registers load on the clk edge where enable & srch_en.
- match_valid is high for exactly the following cycle. On any cycle without an accepted search, match_valid = 0 and match/multi_match/match_addr/match_cnt hold their last values.
- Search with no hit: match = 0, multi_match = 0, match_addr = 0, match_cnt = 0.
- Read-before-write: a search in the same cycle as a write, invalidate or flush compares the pre-edge array state.
- Write: on edge with enable & wr_en, data[wr_addr] <= wr_data, mask[wr_addr] <= wr_mask, valid[wr_addr] <= 1.
- Invalidate: valid[inv_addr] <= 0; data and mask are untouched.
- Priority within one edge: flush > wr_en > inv_en.
  - Flush clears every valid bit and any write in the same cycle is dropped.
  - wr_en and inv_en on the same address: the entry ends valid with the new data.
  - wr_en and inv_en on different addresses: both take effect.
- full and free_addr are combinational from the valid bits, so they reflect state after the most recent edge.
- Overwriting a valid entry is legal; it is not an error.
- match_cnt saturates naturally: CW holds DEPTH exactly.

Decomposition:
- Shared package cam_pkg holds:
  - default DW/DEPTH constants;
  - the clog2 function;
  - localparam widths shared with the table-management FSM.
- Sub-module cam_prio_enc (parameter N): takes an N-bit vector and returns the lowest set index, an any-set flag and a population count.
- cam_prio_enc is instantiated twice:
  - on the hit vector, for match_addr/match/match_cnt;
  - on the inverted valid vector, for free_addr/full.

Test Plan:
- Reset, then search key 16'h1234 -> match_valid=1 next cycle with match=0, match_cnt=0; full=0, free_addr=0.
- Write 16'hABCD mask 16'hFFFF at addr 5 and at addr 9, then search 16'hABCD -> match=1, match_addr=5, multi_match=1, match_cnt=2.
- Write mask 16'hFF00 data 16'h1200 at addr 3, then search 16'h12EE -> match=1, match_addr=3; search 16'h13EE -> match=0.
- Search 16'hABCD in the same cycle as invalidating addr 5 -> result match_addr=5 (old state); next search -> match_addr=9, match_cnt=1.
- Fill all DEPTH entries -> full=1, free_addr=0. Invalidate addr 7 -> full=0, free_addr=7. Flush together with a write to addr 2 -> all invalid, free_addr=0, and a search of the written value misses.
- Assert rst mid-search, with srch_en high during the reset cycle -> outputs go to 0 immediately, with no match_valid pulse after release.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared constants and helpers for the ternary CAM and its table-management logic.
package cam_pkg;

    localparam int DW_DEFAULT    = 16;
    localparam int DEPTH_DEFAULT = 256;

    // Ceiling log2, usable in constant expressions (parameter lists, widths).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int AW_DEFAULT = clog2(DEPTH_DEFAULT);
    localparam int CW_DEFAULT = AW_DEFAULT + 1;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-set-index priority encoder with any-set flag and population count.
module cam_prio_enc
    import cam_pkg::*;
#(
    parameter  int N    = 8,
    localparam int IW   = clog2(N),
    localparam int CNTW = clog2(N) + 1
) (
    input  logic [N-1:0]    vec,
    output logic [IW-1:0]   idx,
    output logic            any,
    output logic [CNTW-1:0] cnt
);

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        idx = '0;
        cnt = '0;
        // Scan downward so the last assignment left standing is the lowest set bit.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
            cnt = cnt + CNTW'(vec[i]);
        end
        any = |vec;
    end

endmodule

// File: rtl/param_cam.sv
// Ternary CAM with valid bits, care-masks, invalidate/flush and a free-entry tracker.
module param_cam
    import cam_pkg::*;
#(
    parameter  int DW    = DW_DEFAULT,
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [DW-1:0] wr_mask,
    input  logic          inv_en,
    input  logic [AW-1:0] inv_addr,
    input  logic          flush,
    input  logic          srch_en,
    input  logic [DW-1:0] srch_key,
    output logic          match_valid,
    output logic          match,
    output logic          multi_match,
    output logic [AW-1:0] match_addr,
    output logic [CW-1:0] match_cnt,
    output logic          full,
    output logic [AW-1:0] free_addr
);

    logic [DW-1:0]    data_mem [DEPTH];
    logic [DW-1:0]    mask_mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] hit;

    logic             accept;
    logic             hit_any;
    logic [AW-1:0]    hit_addr;
    logic [CW-1:0]    hit_cnt;
    logic             free_any;
    logic [CW-1:0]    free_cnt_unused;

    assign accept = enable & srch_en;

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = valid[i] && (((data_mem[i] ^ srch_key) & mask_mem[i]) == '0);
        end
    end

    // NOTE: data/mask storage has no reset; the valid bits alone decide whether an entry exists.
    always_ff @(posedge clk) begin
        if (enable && wr_en && !flush) begin
            data_mem[wr_addr] <= wr_data;
            mask_mem[wr_addr] <= wr_mask;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so the search sees pre-edge contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (enable) begin
            if (flush) begin
                valid <= '0;
            end else begin
                // Write is ordered after invalidate so it wins on a shared address.
                if (inv_en) valid[inv_addr] <= 1'b0;
                if (wr_en)  valid[wr_addr]  <= 1'b1;
            end
        end
    end

    cam_prio_enc #(.N(DEPTH)) u_hit_enc (
        .vec (hit),
        .idx (hit_addr),
        .any (hit_any),
        .cnt (hit_cnt)
    );

    cam_prio_enc #(.N(DEPTH)) u_free_enc (
        .vec (~valid),
        .idx (free_addr),
        .any (free_any),
        .cnt (free_cnt_unused)
    );

    assign full = ~free_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_valid <= 1'b0;
            match       <= 1'b0;
            multi_match <= 1'b0;
            match_addr  <= '0;
            match_cnt   <= '0;
        end else begin
            match_valid <= accept;
            if (accept) begin
                match       <= hit_any;
                multi_match <= (hit_cnt >= CW'(2));
                match_addr  <= hit_addr;
                match_cnt   <= hit_cnt;
            end
        end
    end

endmodule

// File: tb/tb_param_cam.sv
// Scoreboard bench for param_cam: searches push expected results, a monitor pops them.
module tb_param_cam;

    localparam int DW    = 16;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int CW    = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0, wr_en = 1'b0, inv_en = 1'b0, flush = 1'b0, srch_en = 1'b0;
    logic [AW-1:0] wr_addr = '0, inv_addr = '0;
    logic [DW-1:0] wr_data = '0, wr_mask = '0, srch_key = '0;
    logic          match_valid, match, multi_match, full;
    logic [AW-1:0] match_addr, free_addr;
    logic [CW-1:0] match_cnt;

    typedef struct {
        logic          m;
        logic          mm;
        logic [AW-1:0] a;
        logic [CW-1:0] c;
    } res_t;

    res_t          exp_q[$];
    res_t          last;
    int            checks = 0;
    int            errors = 0;
    bit            mvalid [DEPTH];
    logic [DW-1:0] mdata  [DEPTH];
    logic [DW-1:0] mmask  [DEPTH];

    param_cam dut (
        .clk(clk), .rst(rst), .enable(enable),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .inv_en(inv_en), .inv_addr(inv_addr), .flush(flush),
        .srch_en(srch_en), .srch_key(srch_key),
        .match_valid(match_valid), .match(match), .multi_match(multi_match),
        .match_addr(match_addr), .match_cnt(match_cnt),
        .full(full), .free_addr(free_addr)
    );

    always #5 clk = ~clk;

    function automatic res_t model_search(input logic [DW-1:0] key);
        res_t r;
        r.m = 1'b0; r.mm = 1'b0; r.a = '0; r.c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mvalid[i] && (((mdata[i] ^ key) & mmask[i]) == '0)) begin
                if (!r.m) r.a = AW'(i);
                r.m = 1'b1;
                r.c = r.c + 1'b1;
            end
        end
        r.mm = (r.c > 1);
        return r;
    endfunction

    // Monitor: pulses are checked against the scoreboard, idle cycles against the held result.
    always @(negedge clk) begin
        if (rst) begin
            last = '{m: 1'b0, mm: 1'b0, a: '0, c: '0};
        end else if (match_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: match_valid=1 with no search pending");
            end else begin
                res_t e;
                e = exp_q.pop_front();
                if (match !== e.m || multi_match !== e.mm || match_addr !== e.a || match_cnt !== e.c) begin
                    errors++;
                    $display("FAIL scoreboard: got m=%b mm=%b a=%0d c=%0d, expected m=%b mm=%b a=%0d c=%0d",
                             match, multi_match, match_addr, match_cnt, e.m, e.mm, e.a, e.c);
                end
                last = e;
            end
        end else begin
            checks++;
            if (match !== last.m || multi_match !== last.mm || match_addr !== last.a || match_cnt !== last.c) begin
                errors++;
                $display("FAIL hold: got m=%b mm=%b a=%0d c=%0d, expected m=%b mm=%b a=%0d c=%0d",
                         match, multi_match, match_addr, match_cnt, last.m, last.mm, last.a, last.c);
            end
        end
    end

    // Drives one clock of stimulus from a falling edge and updates the model.
    task automatic cycle(input logic en, input logic wr, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [DW-1:0] wm,
                         input logic inv, input logic [AW-1:0] ia, input logic fl,
                         input logic srch, input logic [DW-1:0] key);
        enable = en; wr_en = wr; wr_addr = wa; wr_data = wd; wr_mask = wm;
        inv_en = inv; inv_addr = ia; flush = fl; srch_en = srch; srch_key = key;
        if (en && srch) exp_q.push_back(model_search(key));
        if (en) begin
            if (fl) begin
                for (int i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;
            end else begin
                if (inv) mvalid[ia] = 1'b0;
                if (wr) begin
                    mdata[wa] = wd; mmask[wa] = wm; mvalid[wa] = 1'b1;
                end
            end
        end
        @(negedge clk);
        enable = 1'b0; wr_en = 1'b0; inv_en = 1'b0; flush = 1'b0; srch_en = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        cycle(1'b1, 1'b1, a, d, m, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_search(input logic [DW-1:0] k);
        cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1, k);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({match_valid, match, multi_match, match_addr, match_cnt, full, free_addr} !== '0) begin
            errors++;
            $display("FAIL reset_state: got mv=%b m=%b mm=%b a=%0d c=%0d full=%b free=%0d, expected all 0",
                     match_valid, match, multi_match, match_addr, match_cnt, full, free_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        do_search(16'h1234);
        checks++;
        if (match_valid !== 1'b1 || match !== 1'b0 || match_cnt !== '0 || full !== 1'b0 || free_addr !== '0) begin
            errors++;
            $display("FAIL empty_search: got mv=%b m=%b c=%0d full=%b free=%0d, expected mv=1 m=0 c=0 full=0 free=0",
                     match_valid, match, match_cnt, full, free_addr);
        end
    endtask

    task automatic test_exact_multi;
        do_write(8'd5, 16'hABCD, 16'hFFFF);
        do_write(8'd9, 16'hABCD, 16'hFFFF);
        do_search(16'hABCD);
        checks++;
        if (match !== 1'b1 || match_addr !== 8'd5 || multi_match !== 1'b1 || match_cnt !== 9'd2) begin
            errors++;
            $display("FAIL exact_multi: got m=%b a=%0d mm=%b c=%0d, expected m=1 a=5 mm=1 c=2",
                     match, match_addr, multi_match, match_cnt);
        end
    endtask

    task automatic test_ternary;
        do_write(8'd3, 16'h1200, 16'hFF00);
        do_search(16'h12EE);
        checks++;
        if (match !== 1'b1 || match_addr !== 8'd3 || match_cnt !== 9'd1 || multi_match !== 1'b0) begin
            errors++;
            $display("FAIL ternary_hit: got m=%b a=%0d c=%0d mm=%b, expected m=1 a=3 c=1 mm=0",
                     match, match_addr, match_cnt, multi_match);
        end
        do_search(16'h13EE);
        checks++;
        if (match !== 1'b0 || match_addr !== '0 || match_cnt !== '0) begin
            errors++;
            $display("FAIL ternary_miss: got m=%b a=%0d c=%0d, expected m=0 a=0 c=0", match, match_addr, match_cnt);
        end
    endtask

    task automatic test_read_before_write;
        cycle(1'b1, 1'b0, '0, '0, '0, 1'b1, 8'd5, 1'b0, 1'b1, 16'hABCD);
        checks++;
        if (match_addr !== 8'd5 || match_cnt !== 9'd2) begin
            errors++;
            $display("FAIL rbw_old_state: got a=%0d c=%0d, expected a=5 c=2", match_addr, match_cnt);
        end
        do_search(16'hABCD);
        checks++;
        if (match_addr !== 8'd9 || match_cnt !== 9'd1 || multi_match !== 1'b0) begin
            errors++;
            $display("FAIL rbw_new_state: got a=%0d c=%0d mm=%b, expected a=9 c=1 mm=0", match_addr, match_cnt, multi_match);
        end
    endtask

    task automatic test_enable;
        cycle(1'b0, 1'b1, 8'd0, 16'h0055, 16'hFFFF, 1'b0, '0, 1'b0, 1'b1, 16'h0055);
        checks++;
        if (match_valid !== 1'b0 || free_addr !== 8'd0) begin
            errors++;
            $display("FAIL enable_gate: got mv=%b free=%0d, expected mv=0 free=0", match_valid, free_addr);
        end
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
        do_search(16'hABCD);
        checks++;
        if (match !== 1'b1 || match_addr !== 8'd9) begin
            errors++;
            $display("FAIL enable_flush_gate: got m=%b a=%0d, expected m=1 a=9", match, match_addr);
        end
    endtask

    task automatic test_wr_inv;
        cycle(1'b1, 1'b1, 8'd0, 16'h0055, 16'hFFFF, 1'b1, 8'd0, 1'b0, 1'b0, '0);
        checks++;
        if (free_addr !== 8'd1) begin
            errors++;
            $display("FAIL wr_inv_same: got free=%0d, expected free=1", free_addr);
        end
        cycle(1'b1, 1'b1, 8'd1, 16'h0066, 16'hFFFF, 1'b1, 8'd3, 1'b0, 1'b0, '0);
        checks++;
        if (free_addr !== 8'd2) begin
            errors++;
            $display("FAIL wr_inv_diff_free: got free=%0d, expected free=2", free_addr);
        end
        do_search(16'h12EE);
        checks++;
        if (match !== 1'b0) begin
            errors++;
            $display("FAIL wr_inv_diff_inv: got m=%b, expected m=0", match);
        end
        do_search(16'h0055);
        checks++;
        if (match !== 1'b1 || match_addr !== 8'd0) begin
            errors++;
            $display("FAIL wr_inv_same_data: got m=%b a=%0d, expected m=1 a=0", match, match_addr);
        end
    endtask

    task automatic test_fill_flush;
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), 16'(i), 16'hFFFF);
        checks++;
        if (full !== 1'b1 || free_addr !== 8'd0) begin
            errors++;
            $display("FAIL fill_full: got full=%b free=%0d, expected full=1 free=0", full, free_addr);
        end
        do_write(8'd200, 16'h0000, 16'h0000);
        do_search(16'h0007);
        checks++;
        if (match_addr !== 8'd7 || match_cnt !== 9'd2 || multi_match !== 1'b1) begin
            errors++;
            $display("FAIL mask_zero_multi: got a=%0d c=%0d mm=%b, expected a=7 c=2 mm=1", match_addr, match_cnt, multi_match);
        end
        do_search(16'hFFFF);
        checks++;
        if (match_addr !== 8'd200 || match_cnt !== 9'd1) begin
            errors++;
            $display("FAIL mask_zero_only: got a=%0d c=%0d, expected a=200 c=1", match_addr, match_cnt);
        end
        cycle(1'b1, 1'b0, '0, '0, '0, 1'b1, 8'd7, 1'b0, 1'b0, '0);
        checks++;
        if (full !== 1'b0 || free_addr !== 8'd7) begin
            errors++;
            $display("FAIL inv_free: got full=%b free=%0d, expected full=0 free=7", full, free_addr);
        end
        cycle(1'b1, 1'b1, 8'd2, 16'hBEEF, 16'hFFFF, 1'b0, '0, 1'b1, 1'b0, '0);
        checks++;
        if (full !== 1'b0 || free_addr !== 8'd0) begin
            errors++;
            $display("FAIL flush_free: got full=%b free=%0d, expected full=0 free=0", full, free_addr);
        end
        do_search(16'hBEEF);
        checks++;
        if (match !== 1'b0 || match_cnt !== '0) begin
            errors++;
            $display("FAIL flush_drops_write: got m=%b c=%0d, expected m=0 c=0", match, match_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        do_write(8'd4, 16'h4444, 16'hFFFF);
        do_search(16'h4444);
        checks++;
        if (match !== 1'b1 || match_addr !== 8'd4) begin
            errors++;
            $display("FAIL pre_reset_hit: got m=%b a=%0d, expected m=1 a=4", match, match_addr);
        end
        #2;
        rst = 1'b1; enable = 1'b1; srch_en = 1'b1; srch_key = 16'h4444;
        #1;
        checks++;
        if ({match_valid, match, multi_match, match_addr, match_cnt, full, free_addr} !== '0) begin
            errors++;
            $display("FAIL async_reset: got mv=%b m=%b mm=%b a=%0d c=%0d full=%b free=%0d, expected all 0",
                     match_valid, match, multi_match, match_addr, match_cnt, full, free_addr);
        end
        for (int i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0; enable = 1'b0; srch_en = 1'b0;
        @(negedge clk);
        checks++;
        if (match_valid !== 1'b0 || match !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_pulse: got mv=%b m=%b, expected mv=0 m=0", match_valid, match);
        end
        do_search(16'h4444);
        checks++;
        if (match !== 1'b0) begin
            errors++;
            $display("FAIL reset_clears_valid: got m=%b, expected m=0", match);
        end
    endtask

    initial begin
        last = '{m: 1'b0, mm: 1'b0, a: '0, c: '0};
        for (int i = 0; i < DEPTH; i++) begin
            mvalid[i] = 1'b0; mdata[i] = '0; mmask[i] = '0;
        end
        test_reset();
        test_exact_multi();
        test_ternary();
        test_read_before_write();
        test_enable();
        test_wr_inv();
        test_fill_flush();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_results: %0d expected results never produced, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
